regfile_port_arbiter: RTL
=========================

Name: regfile_port_arbiter

Overview:
Shares the register file's single operand read/write port between two requesters: the core datapath (primary) and the debug/loader port (secondary).
- Fixed priority to the core, with a starvation guard for debug.
- Turns each accepted request into registered regfile controls: operand address, write data, accumulator-write enable and general-register write enable.
- Captures read data and returns it to the requester that issued the read.
- Sits between the control unit/debug logic and the register file.

Parameters:
W, 8, data path width
A, 4, register address width (2**A registers)
MAX_WAIT, 4, consecutive lost-arbitration cycles after which debug takes priority (1..15)

Ports:
Clk  input  1  clock
Reset_n  input  1  asynchronous active-low reset
CoreReq  input  1  core request valid
CoreWe  input  1  1=write, 0=read
CoreAddr  input  A  core register index
CoreWData  input  W  core write data
CoreGnt  output  1  core request accepted this cycle (combinational)
CoreRValid  output  1  RData holds core read result
CoreErr  output  1  core write to R1 rejected
DbgReq, DbgWe, DbgAddr, DbgWData  input  1/1/A/W  debug equivalents
DbgGnt, DbgRValid, DbgErr  output  1  debug equivalents
RData  output  W  captured read data (shared)
RfRaddr  output  A  to regfile Raddr
RfDataIn  output  W  to regfile DataIn
RfWriteR0  output  1  to regfile WriteR0
RfGenRegWrite  output  1  to regfile GenRegWrite
RfDataOperand  input  W  from regfile DataOutOperand

Behaviour:
- Reset state (async, immediate on Reset_n low): all outputs 0; WaitCnt=0; issue register cleared. Write enables clear immediately, so an in-flight write is dropped and never commits.
- Handshake: a transfer occurs on the rising edge where Req&&Gnt. Req and its fields are held stable until then.
- Gnt is combinational from Req and the registered WaitCnt. At most one Gnt per cycle.
- Arbitration:
  - Only core requests -> core granted.
  - Only debug requests -> debug granted.
  - Both request -> core granted, unless WaitCnt==MAX_WAIT, in which case debug is granted.
- WaitCnt:
  - Increments (saturating at MAX_WAIT) each cycle DbgReq&&!DbgGnt.
  - Clears on a debug grant or when DbgReq is low.
- Issue stage: on an accepted transfer in cycle N, cycle N+1 drives RfRaddr=addr and RfDataIn=wdata for one cycle.
- Write-enable decode for cycle N+1:
  - we && addr==0 -> RfWriteR0=1, RfGenRegWrite=0.
  - we && addr>=2 -> RfGenRegWrite=1, RfWriteR0=0.
  - we && addr==1 -> no enables. Err pulses in N+1 to the owner (R1 is hardware-owned by branch target).
  - Read -> no enables.
- With no transfer, enables are 0 and RfRaddr/RfDataIn hold their last values.
- Write commits at the end of N+1.
- Read: RfDataOperand is sampled at the end of N+1, so RData is valid in N+2 with the owner's RValid pulsed for 1 cycle. RData holds until the next read capture.
- Throughput: 1 transfer/cycle. Back-to-back transfers pipeline; RValid pulses may be consecutive and may alternate owners.
- Read-after-write back-to-back to the same address returns the new value (write commits before the read's sampling edge).
- Reset mid-read: the pending RValid is lost; the requester reissues.

Optional Feature:
Macro ARB_STALL_CNT_EN.
- Defined: adds output CoreStallCnt [15:0]. Counts cycles with CoreReq&&!CoreGnt, saturates at 0xFFFF, clears on reset.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
1. Core write addr 5 data 0x3C at cycle 0, then read addr 5 -> CoreGnt in cycles 0 and 1; cycle 1 RfGenRegWrite=1, RfRaddr=5, RfDataIn=0x3C; cycle 3 CoreRValid=1, RData=0x3C.
2. Core write addr 0 data 0xA5, then core write addr 1 data 0x11 -> first: RfWriteR0=1, RfGenRegWrite=0. Second: both enables 0, CoreErr pulses 1 cycle.
3. CoreReq and DbgReq both high for 1 cycle, debug holding -> CoreGnt cycle 0, DbgGnt cycle 1; issue order core then debug.
4. MAX_WAIT=4, core requesting continuously, DbgReq held from cycle 0 -> DbgGnt in cycle 4 (CoreGnt=0 there), core granted in cycles 0-3 and 5+; WaitCnt back to 0.
5. Accept core write addr 7 data 0xFF, assert Reset_n low mid-cycle N+1 -> RfGenRegWrite drops immediately; register 7 unchanged; all Gnt/RValid/Err 0 during reset.
6. ARB_STALL_CNT_EN defined, scenario 4 mirrored with debug priority forced for 3 cycles -> CoreStallCnt=3; reset -> 0.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - core/debug arbiter for the shared regfile operand port
// Optional feature macro: ARB_STALL_CNT_EN (adds o_core_stall_cnt).
module regfile_port_arbiter #(
    parameter int W        = 8,
    parameter int A        = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_core_req,
    input  logic         i_core_we,
    input  logic [A-1:0] i_core_addr,
    input  logic [W-1:0] i_core_wdata,
    output logic         o_core_gnt,
    output logic         o_core_rvalid,
    output logic         o_core_err,
    input  logic         i_dbg_req,
    input  logic         i_dbg_we,
    input  logic [A-1:0] i_dbg_addr,
    input  logic [W-1:0] i_dbg_wdata,
    output logic         o_dbg_gnt,
    output logic         o_dbg_rvalid,
    output logic         o_dbg_err,
    output logic [W-1:0] o_rdata,
    output logic [A-1:0] o_rf_raddr,
    output logic [W-1:0] o_rf_data_in,
    output logic         o_rf_write_r0,
    output logic         o_rf_gen_reg_write,
    input  logic [W-1:0] i_rf_data_operand
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]  o_core_stall_cnt
`endif
);

    localparam logic [3:0]   LP_MAX_WAIT = 4'(MAX_WAIT);
    localparam logic [A-1:0] LP_R1       = A'(1);

    logic [3:0]   r_wait_cnt;
    logic [A-1:0] r_rf_raddr;
    logic [W-1:0] r_rf_data_in;
    logic         r_write_r0;
    logic         r_gen_write;
    logic         r_core_err;
    logic         r_dbg_err;
    logic         r_rd_pend;
    logic         r_rd_owner;
    logic         r_core_rvalid;
    logic         r_dbg_rvalid;
    logic [W-1:0] r_rdata;

    logic         w_dbg_prio;
    logic         w_core_gnt;
    logic         w_dbg_gnt;
    logic         w_xfer;
    logic         w_sel_we;
    logic [A-1:0] w_sel_addr;
    logic [W-1:0] w_sel_wdata;

    // Grants are gated by reset so nothing is accepted while the block is held in reset.
    assign w_dbg_prio  = (r_wait_cnt == LP_MAX_WAIT);
    assign w_core_gnt  = i_rst_n & i_core_req & ~(i_dbg_req & w_dbg_prio);
    assign w_dbg_gnt   = i_rst_n & i_dbg_req & (~i_core_req | w_dbg_prio);
    assign w_xfer      = w_core_gnt | w_dbg_gnt;
    assign w_sel_we    = w_dbg_gnt ? i_dbg_we    : i_core_we;
    assign w_sel_addr  = w_dbg_gnt ? i_dbg_addr  : i_core_addr;
    assign w_sel_wdata = w_dbg_gnt ? i_dbg_wdata : i_core_wdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (!i_dbg_req || w_dbg_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != LP_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rf_raddr    <= '0;
            r_rf_data_in  <= '0;
            r_write_r0    <= 1'b0;
            r_gen_write   <= 1'b0;
            r_core_err    <= 1'b0;
            r_dbg_err     <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_rd_owner    <= 1'b0;
            r_core_rvalid <= 1'b0;
            r_dbg_rvalid  <= 1'b0;
            r_rdata       <= '0;
        end else begin
            // R1 belongs to the branch-target logic: writes to it are refused and flagged.
            r_write_r0  <= w_xfer & w_sel_we & (w_sel_addr == '0);
            r_gen_write <= w_xfer & w_sel_we & (w_sel_addr > LP_R1);
            r_core_err  <= w_core_gnt & i_core_we & (i_core_addr == LP_R1);
            r_dbg_err   <= w_dbg_gnt & i_dbg_we & (i_dbg_addr == LP_R1);
            r_rd_pend   <= w_xfer & ~w_sel_we;
            r_rd_owner  <= w_dbg_gnt;
            if (w_xfer) begin
                r_rf_raddr   <= w_sel_addr;
                r_rf_data_in <= w_sel_wdata;
            end
            r_core_rvalid <= r_rd_pend & ~r_rd_owner;
            r_dbg_rvalid  <= r_rd_pend & r_rd_owner;
            if (r_rd_pend) begin
                r_rdata <= i_rf_data_operand;
            end
        end
    end

`ifdef ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_core_req && !w_core_gnt && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_core_stall_cnt = r_stall_cnt;
`endif

    assign o_core_gnt         = w_core_gnt;
    assign o_dbg_gnt          = w_dbg_gnt;
    assign o_core_rvalid      = r_core_rvalid;
    assign o_dbg_rvalid       = r_dbg_rvalid;
    assign o_core_err         = r_core_err;
    assign o_dbg_err          = r_dbg_err;
    assign o_rdata            = r_rdata;
    assign o_rf_raddr         = r_rf_raddr;
    assign o_rf_data_in       = r_rf_data_in;
    assign o_rf_write_r0      = r_write_r0;
    assign o_rf_gen_reg_write = r_gen_write;

endmodule
